instruction_fetch_unit: RTL and testbench

Fetch stage of the MIPS core and the requesting end of the instruction memory interface. It holds the program counter, drives word addresses into the synchronous instruction memory, captures the instruction code returned one cycle later, and hands instruction/PC pairs to decode over a valid/ready handshake. It absorbs decode stalls without losing or duplicating instructions and restarts fetch on branch/jump redirects.

---
 rtl/mips_pkg.sv | 12 +
 rtl/fetch_skid_buffer.sv | 52 +++++
 rtl/instruction_fetch_unit.sv | 73 +++++++
 tb/tb_instruction_fetch_unit.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: fetch defaults and the {instr, pc} fetch record.
`timescale 1ns/1ps
package mips_pkg;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam int          INSTR_W      = 32;
  localparam logic [31:0] PC_INC       = 32'd4;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
  } fetch_rec_t;
endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry fetch FIFO: output (head) register plus a skid register.
// The head is what decode sees; the skid catches the one response that
// may still land after decode stalls. Data registers hold on flush so the
// outputs keep their last value while invalid.
`timescale 1ns/1ps
module fetch_skid_buffer
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       flush,
  input  logic       push_valid,
  input  fetch_rec_t push_data,
  output logic       out_valid,
  input  logic       out_ready,
  output fetch_rec_t out_data,
  output logic [1:0] count
);
  fetch_rec_t head, skid;
  logic [1:0] cnt;
  logic       deq;

  assign deq       = out_valid && out_ready;
  assign out_valid = (cnt != 2'd0);
  assign out_data  = head;
  assign count     = cnt;

  // Occupancy and data movement; the skid always refills the head before
  // a newly arriving record so ordering is preserved.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head <= '0;
      skid <= '0;
      cnt  <= 2'd0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else if (deq) begin
      if (cnt == 2'd2) begin
        head <= skid;
        if (push_valid) skid <= push_data;
        else            cnt  <= 2'd1;
      end else begin
        if (push_valid) head <= push_data;
        else            cnt  <= 2'd0;
      end
    end else if (push_valid) begin
      if (cnt == 2'd0) head <= push_data;
      else             skid <= push_data;
      cnt <= cnt + 2'd1;
    end
  end
endmodule

// File: rtl/instruction_fetch_unit.sv
// MIPS fetch stage: PC, synchronous imem request/response tracking, and a
// two-entry buffer toward decode. A request is only issued when the buffer
// is guaranteed room for its response one cycle later, so nothing is dropped.
`timescale 1ns/1ps
module instruction_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC
)(
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4
);
  logic [29:0] pc_req;      // word address being requested this cycle
  logic [31:0] pc_rsp;      // byte address whose data is on imem_data now
  logic        rsp_valid;
  logic [1:0]  count;
  logic [2:0]  occ_after;
  logic        deq, issue;
  fetch_rec_t  push_rec, head_rec;
  logic        unused;

  assign unused    = ^redirect_pc[1:0];
  assign imem_addr = {2'b00, pc_req};
  assign deq       = if_valid && if_ready;
  assign push_rec  = '{instr: imem_data, pc: pc_rsp};

  // Worst-case occupancy once this cycle's request returns.
  assign occ_after = {1'b0, count} - {2'b00, deq} + {2'b00, rsp_valid} + 3'd1;
  assign issue     = !redirect_valid && (occ_after <= 3'd2);

  // Request pointer and in-flight tracking; redirect discards the in-flight read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_req    <= RESET_PC[31:2];
      pc_rsp    <= '0;
      rsp_valid <= 1'b0;
    end else if (redirect_valid) begin
      pc_req    <= redirect_pc[31:2];
      rsp_valid <= 1'b0;
    end else if (issue) begin
      pc_req    <= pc_req + 30'd1;
      pc_rsp    <= {pc_req, 2'b00};
      rsp_valid <= 1'b1;
    end else begin
      rsp_valid <= 1'b0;
    end
  end

  fetch_skid_buffer u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (redirect_valid),
    .push_valid (rsp_valid && !redirect_valid),
    .push_data  (push_rec),
    .out_valid  (if_valid),
    .out_ready  (if_ready),
    .out_data   (head_rec),
    .count      (count)
  );

  assign if_instr    = head_rec.instr;
  assign if_pc       = head_rec.pc;
  assign if_pc_plus4 = head_rec.pc + PC_INC;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a synchronous imem model.
`timescale 1ns/1ps
module tb_instruction_fetch_unit;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] imem_addr, imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc, if_pc_plus4;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk(clk), .reset_n(reset_n), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
    .if_pc(if_pc), .if_pc_plus4(if_pc_plus4)
  );

  // mem[i] = 0x20080001 + i (mem[0..3] = 0x20080001..0x20080004)
  function automatic logic [31:0] memval(input int word);
    return 32'h2008_0001 + word;
  endfunction

  always @(posedge clk) imem_data <= memval(int'(imem_addr[5:0]));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // checks valid + pc + instr for an expected byte address
  task automatic expect_out(input string nm, input logic [31:0] pc);
    checks++;
    if (if_valid !== 1'b1 || if_pc !== pc || if_instr !== memval(int'(pc[7:2])) ||
        if_pc_plus4 !== pc + 32'd4) begin
      errors++;
      $display("FAIL %s: valid=%b pc=%h instr=%h pc4=%h, want valid=1 pc=%h instr=%h pc4=%h",
               nm, if_valid, if_pc, if_instr, if_pc_plus4, pc, memval(int'(pc[7:2])), pc + 32'd4);
    end
  endtask

  task automatic expect_invalid(input string nm);
    checks++;
    if (if_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s: if_valid=%b want 0", nm, if_valid);
    end
  endtask

  task automatic expect_addr(input string nm, input logic [31:0] a);
    checks++;
    if (imem_addr !== a) begin
      errors++;
      $display("FAIL %s: imem_addr=%h want %h", nm, imem_addr, a);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; if_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    expect_invalid("reset_valid");
    expect_addr("reset_addr", 32'h0);
    checks++;
    if (if_instr !== 32'h0 || if_pc !== 32'h0 || if_pc_plus4 !== 32'h4) begin
      errors++;
      $display("FAIL reset_outs: instr=%h pc=%h pc4=%h want 0 0 4", if_instr, if_pc, if_pc_plus4);
    end
    @(negedge clk); reset_n = 1'b1;
  endtask

  // edges 1..4 after release: addr k, if_pc (k-2)*4 from edge 2
  task automatic test_stream();
    for (int k = 1; k <= 4; k++) begin
      tick();
      expect_addr($sformatf("stream_addr%0d", k), 32'(k));
      if (k < 2) expect_invalid("stream_first_edge");
      else expect_out($sformatf("stream_pc%0d", k), 32'((k - 2) * 4));
    end
  endtask

  // head at pc 8: stall 3 cycles, then 12,16,20 back-to-back
  task automatic test_stall();
    if_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_out($sformatf("stall_hold%0d", k), 32'h8);
      checks++;
      if (dut.u_fifo.count !== 2'd2) begin
        errors++;
        $display("FAIL stall_count%0d: count=%0d want 2", k, dut.u_fifo.count);
      end
    end
    if_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_out($sformatf("stall_release%0d", k), 32'(12 + 4 * k));
    end
  endtask

  task automatic test_redirect(input logic [31:0] tgt, input string nm);
    redirect_valid = 1'b1; redirect_pc = tgt;
    tick();
    redirect_valid = 1'b0;
    expect_invalid({nm, "_n"});
    expect_addr({nm, "_addr"}, {4'h0, tgt[31:4], 2'b00} >> 0 & 32'h3FFF_FFFF);
    tick();
    expect_invalid({nm, "_n1"});
    tick();
    expect_out({nm, "_tgt"}, {tgt[31:2], 2'b00});
    tick();
    expect_out({nm, "_tgt4"}, {tgt[31:2], 2'b00} + 32'd4);
  endtask

  // fill the FIFO, then redirect while stalled
  task automatic test_redirect_full();
    if_ready = 1'b0;
    tick(); tick();
    checks++;
    if (dut.u_fifo.count !== 2'd2) begin
      errors++;
      $display("FAIL full_count: count=%0d want 2", dut.u_fifo.count);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    tick();
    redirect_valid = 1'b0;
    expect_invalid("full_redir_n");
    expect_addr("full_redir_addr", 32'd32);
    tick();
    expect_invalid("full_redir_n1");
    tick();
    expect_out("full_redir_tgt", 32'h80);
    if_ready = 1'b1;
    tick();
    expect_out("full_redir_tgt4", 32'h84);
  endtask

  task automatic test_reset_mid();
    tick();
    reset_n = 1'b0;
    #1;
    expect_invalid("midreset_async");
    expect_addr("midreset_addr", 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    tick();
    expect_invalid("midreset_edge1");
    expect_addr("midreset_edge1_addr", 32'h1);
    tick();
    expect_out("midreset_edge2", 32'h0);
    tick();
    expect_out("midreset_edge3", 32'h4);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect(32'h40, "redir40");
    test_redirect(32'h43, "redir43");
    test_redirect_full();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
